// File: rtl/sclk_burst_gen_pkg.sv
// rtl/sclk_burst_gen_pkg.sv - shared types, default widths and half-period clamp for sclk_burst_gen
package sclk_burst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_DIV_WIDTH = 16;

  // A zero half-period would give a zero-length level; run it at the fastest legal rate instead.
  function automatic int unsigned clamp_half(input int unsigned hp);
    return (hp == 0) ? 32'd1 : hp;
  endfunction

endpackage

// File: rtl/sclk_burst_gen_if.sv
// rtl/sclk_burst_gen_if.sv - burst request/status bundle; rise/fall exist only with SCLK_BURST_GEN_STROBE_EN
interface sclk_burst_gen_if
  import sclk_burst_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DIV_WIDTH = DEF_DIV_WIDTH
) ();

  logic                 start;
  logic                 stop;
  logic [DIV_WIDTH-1:0] half_period;
  logic [WIDTH-1:0]     n_cycles;
  logic                 sclk;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     count;
`ifdef SCLK_BURST_GEN_STROBE_EN
  logic                 rise;
  logic                 fall;

  modport master (output start, stop, half_period, n_cycles,
                  input  sclk, busy, done, count, rise, fall);
  modport slave  (input  start, stop, half_period, n_cycles,
                  output sclk, busy, done, count, rise, fall);
`else
  modport master (output start, stop, half_period, n_cycles,
                  input  sclk, busy, done, count);
  modport slave  (input  start, stop, half_period, n_cycles,
                  output sclk, busy, done, count);
`endif

endinterface

// File: rtl/sclk_burst_gen_phase_timer.sv
// rtl/sclk_burst_gen_phase_timer.sv - level-length down-counter; expire is high while the count sits at zero
module sclk_phase_timer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] i_load_val,
  output logic                 o_expire
);

  logic [DIV_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/sclk_burst_gen.sv
// rtl/sclk_burst_gen.sv - programmable sclk burst generator with start/busy/done handshake
// Optional rise/fall strobes are built when SCLK_BURST_GEN_STROBE_EN is defined.
module sclk_burst_gen
  import sclk_burst_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
  input logic             clk,
  input logic             reset_n,
  sclk_burst_gen_if.slave bus
);

  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_h;
  logic [WIDTH-1:0]     r_n;
  logic [WIDTH-1:0]     r_count;
  logic                 r_sclk;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_rise;
  logic                 r_fall;

  logic                 w_start_ok;
  logic                 w_expire;
  logic                 w_load;
  logic [DIV_WIDTH-1:0] w_h_in;
  logic [DIV_WIDTH-1:0] w_load_val;

  assign w_start_ok = (r_state == IDLE) && bus.start && !bus.stop;
  assign w_h_in     = DIV_WIDTH'(clamp_half(32'(bus.half_period)));
  // Timer holds H-1 so that each level spans exactly H clk cycles including the load cycle.
  assign w_load     = w_start_ok || ((r_state != IDLE) && w_expire);
  assign w_load_val = (r_state == IDLE) ? (w_h_in - 1'b1) : (r_h - 1'b1);

  sclk_phase_timer #(.DIV_WIDTH(DIV_WIDTH)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_h     <= '0;
      r_n     <= '0;
      r_count <= '0;
      r_sclk  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        IDLE: begin
          r_sclk <= 1'b0;
          r_busy <= 1'b0;
          if (w_start_ok) begin
            r_h     <= w_h_in;
            r_n     <= bus.n_cycles;
            r_count <= {{(WIDTH-1){1'b0}}, 1'b1};
            r_sclk  <= 1'b1;
            r_busy  <= 1'b1;
            r_rise  <= 1'b1;
            r_state <= HIGH;
          end
        end
        HIGH, LOW: begin
          if (bus.stop) begin
            r_fall  <= r_sclk;
            r_sclk  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else if (w_expire && r_state == HIGH) begin
            r_sclk  <= 1'b0;
            r_fall  <= 1'b1;
            r_state <= LOW;
          end else if (w_expire) begin
            if (r_n != '0 && r_count == r_n) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_count <= r_count + 1'b1;
              r_sclk  <= 1'b1;
              r_rise  <= 1'b1;
              r_state <= HIGH;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sclk  = r_sclk;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.count = r_count;
`ifdef SCLK_BURST_GEN_STROBE_EN
  assign bus.rise  = r_rise;
  assign bus.fall  = r_fall;
`else
  logic w_unused_strobes;
  assign w_unused_strobes = r_rise ^ r_fall;
`endif

endmodule
